// File: rtl/otter_mem_pkg.sv
// Shared types and lane helpers for the OTTER memory-port to AXI4-Lite bridge.
//   size_t  : CPU access size encoding (3 is not listed and behaves as WORD)
//   state_t : bridge FSM states, also exported on the bridge debug port
//   align_offset / lane_strb / size_mask : byte-lane arithmetic on a 32-bit bus
package otter_mem_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } size_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,   // AW and W outstanding
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Force a byte offset down to the natural alignment of the access size.
    function automatic logic [1:0] align_offset(input logic [1:0] off, input logic [1:0] sz);
        logic [1:0] r;
        if (sz == BYTE)      r = off;
        else if (sz == HALF) r = {off[1], 1'b0};
        else                 r = 2'b00;
        return r;
    endfunction

    // Byte strobes for an access of size sz starting at byte lane off.
    function automatic logic [3:0] lane_strb(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] base;
        if (sz == BYTE)      base = 4'b0001;
        else if (sz == HALF) base = 4'b0011;
        else                 base = 4'b1111;
        return base << off;
    endfunction

    // Mask that keeps the low 8/16/32 bits of a right-aligned read value.
    function automatic logic [31:0] size_mask(input logic [1:0] sz);
        logic [31:0] m;
        if (sz == BYTE)      m = 32'h0000_00FF;
        else if (sz == HALF) m = 32'h0000_FFFF;
        else                 m = 32'hFFFF_FFFF;
        return m;
    endfunction

endpackage

// File: rtl/otter_axi_rw_bridge_if.sv
// Single-beat AXI4-Lite bus between the bridge (master) and memory/interconnect (slave).
// Channels: AW (awaddr/awprot/awvalid/awready), W (wdata/wstrb/wvalid/wready),
//           B (bresp/bvalid/bready), AR (araddr/arprot/arvalid/arready),
//           R (rdata/rresp/rvalid/rready).
//
// Handshake rule on every channel: a beat transfers on the rising clk edge where
// valid and ready are both 1. Once valid is raised it stays high, with its
// payload stable, until that edge; ready may rise and fall freely and never
// has to wait for valid.
interface otter_axi_rw_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/otter_lane_align.sv
// Combinational byte-lane steering for a 32-bit bus.
//   size, offset : access size and (already aligned) byte offset
//   wr_data      : right-aligned CPU write data -> wdata placed on its lanes
//   wstrb        : byte strobes matching wdata
//   rd_data      : raw bus read data -> rd_value right-aligned and zero-extended
module otter_lane_align
    import otter_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] wr_data,
    input  logic [31:0] rd_data,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] rd_value
);
    logic [4:0] shamt;

    assign shamt    = {offset, 3'b000};
    assign wstrb    = lane_strb(size, offset);
    // Upper din bits are not masked: strobes already mark the valid lanes.
    assign wdata    = wr_data << shamt;
    assign rd_value = (rd_data >> shamt) & size_mask(size);
endmodule

// File: rtl/otter_axi_rw_bridge.sv
// Turns the OTTER single-access memory port into single-beat AXI4-Lite transactions.
// The requester sees a blocking access: stall stays high until the AXI response
// has returned, then drops for exactly one cycle (DONE).
//   clk, rst          : clock, synchronous active-high reset
//   mem_read/mem_write: level requests held by the CPU until stall falls
//   size, addr, din   : access size, byte address, right-aligned write data
//   dout              : last completed read, right-aligned, zero-extended
//   stall             : access in flight
//   dbg_state         : current FSM state
//   axi               : AXI4-Lite master side
module otter_axi_rw_bridge
    import otter_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              stall,
    output state_t            dbg_state,
    otter_axi_rw_bridge_if.master axi
);
    state_t            state, next_state;
    logic [ADDR_W-1:0] req_addr;     // already naturally aligned
    logic [1:0]        req_size;
    logic [DATA_W-1:0] req_din;
    logic              aw_done, w_done;
    logic              aw_hs, w_hs;
    logic [ADDR_W-1:0] aligned_addr;
    logic [31:0]       rd_value;
    logic              unused_resp;

    assign aligned_addr = {addr[ADDR_W-1:2], align_offset(addr[1:0], size)};

    // Response codes are deliberately ignored; error responses complete normally.
    assign unused_resp = ^{axi.bresp, axi.rresp};

    // Valids come straight from registered state, so they rise the cycle after
    // IDLE accepts and never depend combinationally on the slave.
    assign axi.awvalid = (state == WR) && !aw_done;
    assign axi.wvalid  = (state == WR) && !w_done;
    assign axi.bready  = (state == WRESP);
    assign axi.arvalid = (state == RADDR);
    assign axi.rready  = (state == RDATA);
    assign axi.awaddr  = req_addr;
    assign axi.araddr  = req_addr;
    assign axi.awprot  = 3'b000;
    assign axi.arprot  = 3'b000;

    assign aw_hs = axi.awvalid & axi.awready;
    assign w_hs  = axi.wvalid & axi.wready;

    assign stall     = (mem_read | mem_write) && (state != DONE) && !rst;
    assign dbg_state = state;

    otter_lane_align u_lane_align (
        .size     (req_size),
        .offset   (req_addr[1:0]),
        .wr_data  (req_din),
        .rd_data  (axi.rdata),
        .wstrb    (axi.wstrb),
        .wdata    (axi.wdata),
        .rd_value (rd_value)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (mem_write)     next_state = WR;
                else if (mem_read) next_state = RADDR;
            end
            // AW and W may finish in either order or together.
            WR:    if ((aw_done | aw_hs) && (w_done | w_hs)) next_state = WRESP;
            WRESP: if (axi.bvalid)  next_state = DONE;
            RADDR: if (axi.arready) next_state = RDATA;
            RDATA: if (axi.rvalid)  next_state = DONE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            req_addr <= '0;
            req_size <= 2'b00;
            req_din  <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            dout     <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                if (mem_write || mem_read) begin
                    req_addr <= aligned_addr;
                    req_size <= size;
                    req_din  <= din;
                end
            end else if (state == WR) begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
            if (state == RDATA && axi.rvalid) dout <= rd_value;
        end
    end
endmodule

// File: tb/tb_otter_axi_rw_bridge.sv
module tb_otter_axi_rw_bridge;
    import otter_mem_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        mem_read, mem_write;
    logic [1:0]  size;
    logic [31:0] addr, din, dout;
    logic        stall;
    state_t      dbg_state;

    otter_axi_rw_bridge_if bus ();

    otter_axi_rw_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .size      (size),
        .addr      (addr),
        .din       (din),
        .dout      (dout),
        .stall     (stall),
        .dbg_state (dbg_state),
        .axi       (bus)
    );

    // ---------------- AXI slave model with programmable waits ----------------
    int aw_lat = 0, w_lat = 0, ar_lat = 0, r_lat = 0;
    logic [31:0] rdata_val = 32'h0;
    int aw_cnt, w_cnt, ar_cnt, r_cnt;
    logic aw_got, w_got, r_pending;
    int aw_beats = 0, w_beats = 0, ar_beats = 0;
    int aw_vcyc = 0, w_vcyc = 0, ar_vcyc = 0;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;
    logic aw_hs, w_hs, ar_hs;

    assign bus.awready = bus.awvalid && (aw_cnt >= aw_lat);
    assign bus.wready  = bus.wvalid && (w_cnt >= w_lat);
    assign bus.arready = bus.arvalid && (ar_cnt >= ar_lat);
    assign bus.bresp   = 2'b10;   // error codes must not change the flow
    assign bus.rresp   = 2'b11;
    assign aw_hs = bus.awvalid & bus.awready;
    assign w_hs  = bus.wvalid & bus.wready;
    assign ar_hs = bus.arvalid & bus.arready;

    always @(posedge clk) begin
        if (rst) begin
            bus.bvalid <= 1'b0;
            bus.rvalid <= 1'b0;
            bus.rdata  <= 32'h0;
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; r_pending <= 1'b0;
        end else begin
            if (bus.awvalid) aw_vcyc <= aw_vcyc + 1;
            if (bus.wvalid)  w_vcyc  <= w_vcyc + 1;
            if (bus.arvalid) ar_vcyc <= ar_vcyc + 1;
            if (aw_hs) begin
                aw_beats <= aw_beats + 1; cap_awaddr <= bus.awaddr; aw_cnt <= 0;
            end else if (bus.awvalid) aw_cnt <= aw_cnt + 1;
            if (w_hs) begin
                w_beats <= w_beats + 1; cap_wdata <= bus.wdata; cap_wstrb <= bus.wstrb; w_cnt <= 0;
            end else if (bus.wvalid) w_cnt <= w_cnt + 1;
            if (ar_hs) begin
                ar_beats <= ar_beats + 1; cap_araddr <= bus.araddr; ar_cnt <= 0;
            end else if (bus.arvalid) ar_cnt <= ar_cnt + 1;

            if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
            else if ((aw_got | aw_hs) && (w_got | w_hs)) begin
                bus.bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs)  w_got  <= 1'b1;
            end

            if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
            else if (ar_hs) begin
                if (r_lat == 0) begin
                    bus.rvalid <= 1'b1; bus.rdata <= rdata_val;
                end else begin
                    r_pending <= 1'b1; r_cnt <= 1;
                end
            end else if (r_pending) begin
                if (r_cnt >= r_lat) begin
                    bus.rvalid <= 1'b1; bus.rdata <= rdata_val; r_pending <= 1'b0;
                end else r_cnt <= r_cnt + 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // op: 0 write, 1 read, 2 read+write together
    typedef struct {
        int          op;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        int          awl, wl, arl, rl;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_strb;
        logic [31:0] e_dout;
        int          e_lat;
    } vec_t;

    vec_t vecs[12];

    // ---------------- driver ----------------
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        int b_aw, b_w, b_ar, c_aw, c_w, c_ar;
        logic [31:0] e;
        @(negedge clk);
        aw_lat = v.awl; w_lat = v.wl; ar_lat = v.arl; r_lat = v.rl;
        rdata_val = v.rd;
        b_aw = aw_beats; b_w = w_beats; b_ar = ar_beats;
        c_aw = aw_vcyc;  c_w = w_vcyc;  c_ar = ar_vcyc;
        mem_write = (v.op != 1);
        mem_read  = (v.op != 0);
        size = v.sz; addr = v.a; din = v.d;
        if (v.op == 1) exp_q.push_back(v.e_dout);
        #1;
        lat = 1;
        while (stall && lat < 60) begin
            @(posedge clk); @(negedge clk); lat++;
        end
        check({tag, " latency"}, lat, v.e_lat);
        check({tag, " state DONE"}, 32'(dbg_state), 32'(DONE));
        if (v.op != 1) begin
            check({tag, " awaddr"}, cap_awaddr, v.e_addr);
            check({tag, " wdata"}, cap_wdata, v.e_wdata);
            check({tag, " wstrb"}, 32'(cap_wstrb), 32'(v.e_strb));
            check({tag, " aw beats"}, aw_beats - b_aw, 1);
            check({tag, " w beats"}, w_beats - b_w, 1);
            check({tag, " awvalid cycles"}, aw_vcyc - c_aw, v.awl + 1);
            check({tag, " wvalid cycles"}, w_vcyc - c_w, v.wl + 1);
            check({tag, " arvalid cycles"}, ar_vcyc - c_ar, 0);
            check({tag, " dout held"}, dout, v.e_dout);
        end else begin
            e = exp_q.pop_front();
            check({tag, " araddr"}, cap_araddr, v.e_addr);
            check({tag, " dout"}, dout, e);
            check({tag, " ar beats"}, ar_beats - b_ar, 1);
            check({tag, " arvalid cycles"}, ar_vcyc - c_ar, v.arl + 1);
            check({tag, " awvalid cycles"}, aw_vcyc - c_aw, 0);
        end
        mem_write = 1'b0; mem_read = 1'b0;
        @(posedge clk); @(negedge clk);
        check({tag, " back to IDLE"}, 32'(dbg_state), 32'(IDLE));
        check({tag, " stall idle"}, 32'(stall), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int b_ar;
        vec_t rv;
        //           op sz  addr      din           rdata         awl wl arl rl exp_addr  exp_wdata     strb   exp_dout      lat
        vecs[0]  = '{0, 2'd2, 32'h10, 32'hDEADBEEF, 32'h0,        0, 0, 0, 0, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,        4};
        vecs[1]  = '{0, 2'd0, 32'h13, 32'h000000AB, 32'h0,        0, 0, 0, 0, 32'h13, 32'hAB000000, 4'h8, 32'h0,        4};
        vecs[2]  = '{1, 2'd1, 32'h22, 32'h0,        32'h1234ABCD, 0, 0, 0, 0, 32'h22, 32'h0,        4'h0, 32'h00001234, 4};
        vecs[3]  = '{0, 2'd1, 32'h05, 32'h0000BEEF, 32'h0,        0, 0, 0, 0, 32'h04, 32'h0000BEEF, 4'h3, 32'h00001234, 4};
        vecs[4]  = '{1, 2'd0, 32'h31, 32'h0,        32'hA1B2C3D4, 0, 0, 0, 0, 32'h31, 32'h0,        4'h0, 32'h000000C3, 4};
        vecs[5]  = '{1, 2'd2, 32'h47, 32'h0,        32'hCAFEF00D, 0, 0, 0, 0, 32'h44, 32'h0,        4'h0, 32'hCAFEF00D, 4};
        vecs[6]  = '{1, 2'd3, 32'h52, 32'h0,        32'h0BADBEEF, 0, 0, 0, 0, 32'h50, 32'h0,        4'h0, 32'h0BADBEEF, 4};
        vecs[7]  = '{2, 2'd1, 32'h62, 32'h00005A5A, 32'h0,        0, 0, 0, 0, 32'h62, 32'h5A5A0000, 4'hC, 32'h0BADBEEF, 4};
        vecs[8]  = '{0, 2'd2, 32'h80, 32'h11223344, 32'h0,        3, 0, 0, 0, 32'h80, 32'h11223344, 4'hF, 32'h0BADBEEF, 7};
        vecs[9]  = '{0, 2'd0, 32'h01, 32'h00000077, 32'h0,        0, 2, 0, 0, 32'h01, 32'h00007700, 4'h2, 32'h0BADBEEF, 6};
        vecs[10] = '{1, 2'd1, 32'h23, 32'h0,        32'hFFEE1122, 0, 0, 2, 0, 32'h22, 32'h0,        4'h0, 32'h0000FFEE, 6};
        vecs[11] = '{1, 2'd0, 32'h92, 32'h0,        32'h55667788, 0, 0, 0, 3, 32'h92, 32'h0,        4'h0, 32'h00000066, 7};

        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        size = 2'd0; addr = 32'h0; din = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset state", 32'(dbg_state), 32'(IDLE));
        check("reset stall", 32'(stall), 0);
        check("reset dout", dout, 0);
        check("reset valids", 32'({bus.awvalid, bus.wvalid, bus.arvalid}), 0);
        check("reset readies", 32'({bus.bready, bus.rready}), 0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Request still held after DONE starts a fresh access.
        @(negedge clk);
        aw_lat = 0; ar_lat = 0; r_lat = 0; rdata_val = 32'h13572468;
        b_ar = ar_beats;
        mem_read = 1'b1; size = 2'd2; addr = 32'h100;
        #1;
        n = 0;
        while (stall && n < 40) begin @(posedge clk); @(negedge clk); n++; end
        check("hold first dout", dout, 32'h13572468);
        check("hold first DONE", 32'(dbg_state), 32'(DONE));
        @(posedge clk); @(negedge clk);
        check("hold re-stall", 32'(stall), 1);
        check("hold IDLE again", 32'(dbg_state), 32'(IDLE));
        @(posedge clk); @(negedge clk);
        check("hold new RADDR", 32'(dbg_state), 32'(RADDR));
        n = 0;
        while (stall && n < 40) begin @(posedge clk); @(negedge clk); n++; end
        check("hold second dout", dout, 32'h13572468);
        check("hold ar beats", ar_beats - b_ar, 2);
        mem_read = 1'b0;
        @(posedge clk); @(negedge clk);

        // Reset while waiting in RDATA.
        r_lat = 8; rdata_val = 32'hFFFFFFFF;
        mem_read = 1'b1; size = 2'd0; addr = 32'h200;
        n = 0;
        while (dbg_state != RDATA && n < 20) begin @(posedge clk); @(negedge clk); n++; end
        check("rst reach RDATA", 32'(dbg_state), 32'(RDATA));
        rst = 1'b1;
        #1;
        check("rst stall forced low", 32'(stall), 0);
        check("rst dout before edge", dout, 32'h13572468);
        @(posedge clk); @(negedge clk);
        check("rst state IDLE", 32'(dbg_state), 32'(IDLE));
        check("rst rready", 32'(bus.rready), 0);
        check("rst arvalid", 32'(bus.arvalid), 0);
        check("rst dout cleared", dout, 0);
        check("rst stall", 32'(stall), 0);
        mem_read = 1'b0; rst = 1'b0;

        // Normal access right after the aborted one.
        rv = '{1, 2'd2, 32'h300, 32'h0, 32'h0F0F0F0F, 0, 0, 0, 0, 32'h300, 32'h0, 4'h0, 32'h0F0F0F0F, 4};
        run_vec(rv, "post-rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
